// File: rtl/lsu.sv
// Load/store unit: one req/ack data-memory transaction per request, with byte-lane
// formatting, misalignment trapping and a bus watchdog.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_w_i,
  input  logic        rst_w_i_h,
  input  logic        req_w_i_h,
  input  logic        we_w_i_h,
  input  logic [2:0]  funct3_w_i,
  input  logic [31:0] addr_w_i,
  input  logic [31:0] store_data_w_i,
  output logic        busy_w_o_h,
  output logic        done_w_o_h,
  output logic [31:0] load_data_w_o,
  output logic        misaligned_w_o_h,
  output logic        timeout_w_o_h,
  output logic        mem_req_w_o_h,
  output logic        mem_we_w_o_h,
  output logic [31:0] mem_addr_w_o,
  output logic [3:0]  mem_be_w_o,
  output logic [31:0] mem_wdata_w_o,
  input  logic [31:0] mem_rdata_w_i,
  input  logic        mem_ack_w_i_h
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_next;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] sd_q;
  logic [7:0]  cnt;
  logic        illegal;
  logic        hit_limit;
  logic [31:0] lane;
  logic [31:0] load_fmt;

  always_comb begin
    illegal = 1'b0;
    case (funct3_w_i)
      3'b000, 3'b100: illegal = 1'b0;
      3'b001, 3'b101: illegal = addr_w_i[0];
      3'b010:         illegal = (addr_w_i[1:0] != 2'b00);
      default:        illegal = 1'b1;
    endcase
    if (we_w_i_h && funct3_w_i[2])
      illegal = 1'b1;
  end

  // The cycle in which cnt+1 reaches the limit is the last one mem_req is high.
  assign hit_limit = (({1'b0, cnt} + 9'd1) == 9'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_w_i or posedge rst_w_i_h) begin
    if (rst_w_i_h)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_w_i_h) state_next = illegal ? DONE : ACCESS;
      ACCESS:  if (mem_ack_w_i_h || hit_limit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    lane     = mem_rdata_w_i >> {addr_q[1:0], 3'b000};
    load_fmt = mem_rdata_w_i;
    case (f3_q)
      3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_fmt = {24'd0, lane[7:0]};
      3'b101:  load_fmt = {16'd0, lane[15:0]};
      default: load_fmt = mem_rdata_w_i;
    endcase
  end

  always_ff @(posedge clk_w_i or posedge rst_w_i_h) begin
    if (rst_w_i_h) begin
      we_q             <= 1'b0;
      f3_q             <= '0;
      addr_q           <= '0;
      sd_q             <= '0;
      cnt              <= '0;
      load_data_w_o    <= '0;
      misaligned_w_o_h <= 1'b0;
      timeout_w_o_h    <= 1'b0;
    end else begin
      misaligned_w_o_h <= 1'b0;
      timeout_w_o_h    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_w_i_h) begin
            we_q   <= we_w_i_h;
            f3_q   <= funct3_w_i;
            addr_q <= addr_w_i;
            sd_q   <= store_data_w_i;
            cnt    <= '0;
            if (illegal) begin
              misaligned_w_o_h <= 1'b1;
              if (!we_w_i_h) load_data_w_o <= '0;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 8'd1;
          if (mem_ack_w_i_h) begin
            if (!we_q) load_data_w_o <= load_fmt;
          end else if (hit_limit) begin
            timeout_w_o_h <= 1'b1;
            if (!we_q) load_data_w_o <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_be_w_o    = 4'b0000;
    mem_wdata_w_o = sd_q;
    case (f3_q[1:0])
      2'b00: begin
        mem_be_w_o    = 4'b0001 << addr_q[1:0];
        mem_wdata_w_o = {4{sd_q[7:0]}};
      end
      2'b01: begin
        mem_be_w_o    = 4'b0011 << {addr_q[1], 1'b0};
        mem_wdata_w_o = {2{sd_q[15:0]}};
      end
      default: begin
        mem_be_w_o    = 4'b1111;
        mem_wdata_w_o = sd_q;
      end
    endcase
    if (!we_q)
      mem_be_w_o = 4'b0000;
  end

  assign busy_w_o_h    = (state != IDLE);
  assign done_w_o_h    = (state == DONE);
  assign mem_req_w_o_h = (state == ACCESS);
  assign mem_we_w_o_h  = we_q;
  assign mem_addr_w_o  = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_lsu.sv
// Directed scoreboard bench for lsu: stimulus pushes expected completions, a negedge
// monitor pops and compares them and checks bus fields during ACCESS.
module tb_lsu;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] sd = '0;
  logic [31:0] rdata = '0;
  logic        ack = 1'b0;
  logic        busy, done, mis, tmo, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_w_i(clk), .rst_w_i_h(rst), .req_w_i_h(req), .we_w_i_h(we),
    .funct3_w_i(f3), .addr_w_i(addr), .store_data_w_i(sd),
    .busy_w_o_h(busy), .done_w_o_h(done), .load_data_w_o(load_data),
    .misaligned_w_o_h(mis), .timeout_w_o_h(tmo),
    .mem_req_w_o_h(mem_req), .mem_we_w_o_h(mem_we), .mem_addr_w_o(mem_addr),
    .mem_be_w_o(mem_be), .mem_wdata_w_o(mem_wdata),
    .mem_rdata_w_i(rdata), .mem_ack_w_i_h(ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mis;
    logic        tmo;
    logic [31:0] data;
  } resp_t;

  resp_t       exp_q[$];
  int          nvec = 0;
  int          nerr = 0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_wd = '0;
  logic [3:0]  exp_be = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    resp_t e;
    if (!rst) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_done: got done=1 want no completion (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("misaligned", {31'd0, mis}, {31'd0, e.mis});
          chk("timeout", {31'd0, tmo}, {31'd0, e.tmo});
          chk("load_data", load_data, e.data);
        end
      end else begin
        chk("flags_outside_done", {30'd0, mis, tmo}, 32'd0);
      end
      if (mem_req) begin
        chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_be", {28'd0, mem_be}, {28'd0, exp_be});
        if (exp_we) chk("mem_wdata", mem_wdata, exp_wd);
      end
    end
  end

  // Called at posedge+1 in an IDLE cycle; returns at posedge+1 of the cycle after done.
  // wait_n < 0 means the bus never acks; otherwise ack arrives in cycle wait_n+1.
  task automatic run(input logic w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, input int wait_n, input logic [31:0] rd,
                     input logic emis, input logic etmo, input logic [31:0] edata,
                     input logic [3:0] ebe, input logic [31:0] ewd,
                     input int elat, input int ereq);
    resp_t r;
    int reqcnt;
    int lat;
    reqcnt = 0;
    lat    = 0;
    r.mis  = emis;
    r.tmo  = etmo;
    r.data = edata;
    exp_q.push_back(r);
    exp_we   = w;
    exp_addr = {a[31:2], 2'b00};
    exp_be   = ebe;
    exp_wd   = ewd;
    we = w; f3 = f; addr = a; sd = d; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      ack   = (wait_n >= 0) && (n == wait_n + 1);
      rdata = ack ? rd : 32'h5A5A_5A5A;
      @(negedge clk);
      if (mem_req) reqcnt++;
      if (done) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    ack = 1'b0;
    if (lat == 0) $display("FAIL done_wait: got no done within 40 cycles want done");
    chk("latency", 32'(lat), 32'(elat));
    chk("mem_req_cycles", 32'(reqcnt), 32'(ereq));
    @(posedge clk); #1;
  endtask

  logic [31:0] b2b_rd [3];
  logic [31:0] b2b_ex [3];

  initial begin
    int reqcnt, ndone, acc;
    int dcyc [3];
    resp_t r;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_flags", {30'd0, mis, tmo}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    //   we    f3      addr          sd            wait rdata         mis   tmo   data          be       wdata         lat req
    run(1'b0, 3'b000, 32'h0000_1003, 32'h0,         0, 32'h80AB_CDEF, 1'b0, 1'b0, 32'hFFFF_FF80, 4'b0000, 32'h0,         2, 1);
    run(1'b1, 3'b001, 32'h0000_2002, 32'h1234_BEEF, 3, 32'h0,         1'b0, 1'b0, 32'hFFFF_FF80, 4'b1100, 32'hBEEF_BEEF, 5, 4);
    run(1'b0, 3'b010, 32'h0000_3001, 32'h0,        -1, 32'h0,         1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,         1, 0);
    run(1'b0, 3'b011, 32'h0000_3001, 32'h0,        -1, 32'h0,         1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,         1, 0);
    run(1'b0, 3'b101, 32'h0000_4002, 32'h0,         1, 32'h8765_4321, 1'b0, 1'b0, 32'h0000_8765, 4'b0000, 32'h0,         3, 2);
    run(1'b1, 3'b000, 32'h0000_5001, 32'hAABB_CC7E, 0, 32'h0,         1'b0, 1'b0, 32'h0000_8765, 4'b0010, 32'h7E7E_7E7E, 2, 1);
    run(1'b0, 3'b001, 32'h0000_4002, 32'h0,         0, 32'h8765_4321, 1'b0, 1'b0, 32'hFFFF_8765, 4'b0000, 32'h0,         2, 1);
    run(1'b1, 3'b100, 32'h0000_6000, 32'h1111_2222,-1, 32'h0,         1'b1, 1'b0, 32'hFFFF_8765, 4'b0000, 32'h0,         1, 0);
    run(1'b1, 3'b010, 32'h0000_6000, 32'hCAFE_F00D, 2, 32'h0,         1'b0, 1'b0, 32'hFFFF_8765, 4'b1111, 32'hCAFE_F00D, 4, 3);
    run(1'b0, 3'b010, 32'h0000_4000, 32'h0,        -1, 32'h0,         1'b0, 1'b1, 32'h0,         4'b0000, 32'h0,         5, 4);
    run(1'b0, 3'b001, 32'h0000_7001, 32'h0,        -1, 32'h0,         1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,         1, 0);
    run(1'b0, 3'b010, 32'h0000_7000, 32'h0,         3, 32'h0102_0304, 1'b0, 1'b0, 32'h0102_0304, 4'b0000, 32'h0,         5, 4);

    // Back-to-back LBU with req held high; the responder acks whenever mem_req is up.
    b2b_rd[0] = 32'h0000_9A00; b2b_ex[0] = 32'h0000_009A;
    b2b_rd[1] = 32'h1234_5678; b2b_ex[1] = 32'h0000_0056;
    b2b_rd[2] = 32'hFFFF_C3FF; b2b_ex[2] = 32'h0000_00C3;
    for (int i = 0; i < 3; i++) begin
      r.mis = 1'b0; r.tmo = 1'b0; r.data = b2b_ex[i];
      exp_q.push_back(r);
    end
    exp_we = 1'b0; exp_addr = 32'h0000_0100; exp_be = 4'b0000;
    we = 1'b0; f3 = 3'b100; addr = 32'h0000_0101; sd = 32'h0; req = 1'b1;
    reqcnt = 0; ndone = 0; acc = 0;
    @(posedge clk); #1;
    for (int n = 1; n <= 30 && ndone < 3; n++) begin
      ack   = mem_req;
      rdata = (acc < 3) ? b2b_rd[acc] : 32'h0;
      @(negedge clk);
      if (mem_req) reqcnt++;
      if (done) begin
        dcyc[ndone] = n;
        ndone++;
        if (ndone == 3) req = 1'b0;
      end
      @(posedge clk);
      if (ack) acc++;
      #1;
    end
    ack = 1'b0;
    req = 1'b0;
    chk("b2b_done_count", 32'(ndone), 32'd3);
    chk("b2b_first_done", 32'(dcyc[0]), 32'd2);
    chk("b2b_period_1", 32'(dcyc[1] - dcyc[0]), 32'd3);
    chk("b2b_period_2", 32'(dcyc[2] - dcyc[1]), 32'd3);
    chk("b2b_bus_cycles", 32'(reqcnt), 32'd3);
    @(posedge clk); #1;

    // Spurious ack while idle.
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    chk("spurious_ack_busy", {31'd0, busy}, 32'd0);
    chk("spurious_ack_mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;

    // Reset in the second ACCESS cycle of a never-acked load.
    exp_we = 1'b0; exp_addr = 32'h0000_8000; exp_be = 4'b0000;
    we = 1'b0; f3 = 3'b010; addr = 32'h0000_8000; sd = 32'hFFFF_FFFF; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_mem_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_load_data", load_data, 32'd0);
    chk("arst_mem_addr", mem_addr, 32'd0);
    chk("arst_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run(1'b0, 3'b010, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, 4'b0000, 32'h0, 2, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("pending_completions", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish before 200000");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RV32 core, directly downstream of the ALU. It takes the ALU result as the effective address and runs one data-memory transaction per request over a req/ack bus. It generates byte enables and replicated store data, and aligns and extends load data. Misaligned and invalid accesses are trapped without touching memory, and a stuck bus is aborted by a watchdog.

## Interface
- TIMEOUT_CYCLES, 255: max cycles in ACCESS without `mem_ack_w_i_h` before abort; range 1..255.
- clk_w_i  input  1  clock, rising edge.
- rst_w_i_h  input  1  reset, asynchronous, active-high.
- req_w_i_h  input  1  start request; sampled only in IDLE.
- we_w_i_h  input  1  1 = store, 0 = load.
- funct3_w_i  input  3  size/sign:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - stores: 000 SB, 001 SH, 010 SW.
- addr_w_i  input  32  effective address (ALU result).
- store_data_w_i  input  32  rs2 value.
- busy_w_o_h  output  1  high whenever state ≠ IDLE.
- done_w_o_h  output  1  one-cycle completion pulse.
- load_data_w_o  output  32  registered, extended load result.
- misaligned_w_o_h  output  1  error flag, valid with done.
- timeout_w_o_h  output  1  error flag, valid with done.
- mem_req_w_o_h  output  1  bus request.
- mem_we_w_o_h  output  1  bus write.
- mem_addr_w_o  output  32  word address, {addr[31:2],2'b00}.
- mem_be_w_o  output  4  byte enables; 4'b0000 on loads.
- mem_wdata_w_o  output  32  lane-replicated store data.
- mem_rdata_w_i  input  32  read data, valid with ack.
- mem_ack_w_i_h  input  1  bus acknowledge.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - req=1 captures we, funct3, addr and store_data into internal registers.
  - Illegal request → DONE with misaligned=1. Illegal means any of:
    - LH/LHU/SH with addr[0]=1;
    - LW/SW with addr[1:0]≠0;
    - funct3 ∈ {011,110,111};
    - a store with funct3[2]=1.
  - Otherwise → ACCESS; watchdog counter cleared.
- ACCESS:
  - mem_req=1, and mem_we/addr/be/wdata are driven from the captured registers, held constant until exit.
  - ack=1 → DONE. On a load, load_data is updated from mem_rdata this same edge.
  - Counter reaches TIMEOUT_CYCLES with no ack → DONE with timeout=1.
- DONE: done=1 for one cycle, then IDLE.
- Store formatting:
  - SB: be = 4'b0001<<addr[1:0], wdata = {4{sd[7:0]}}.
  - SH: be = 4'b0011<<{addr[1],1'b0}, wdata = {2{sd[15:0]}}.
  - SW: be = 4'b1111, wdata = sd.
- Load formatting:
  - lane = rdata >> (8·addr[1:0]).
  - LB/LH sign-extend lane[7:0] / lane[15:0].
  - LBU/LHU zero-extend. LW passes rdata through.
- load_data_w_o:
  - Load completing with an error → 0.
  - Store completion → unchanged.
  - Otherwise holds its value until the next load completes.
- misaligned and timeout are registered and valid only while done=1; 0 in all other cycles. They are never both 1.

## Timing
- Reset (asynchronous): state IDLE, counter 0, and every output 0, including load_data, mem_addr, mem_be and mem_wdata.
- Reset mid-ACCESS: mem_req drops immediately (asynchronous) and no done is produced.
- Latency, accepted access: req sampled at edge 0; mem_req high from cycle 1. Ack in cycle k (k≥1) → done in cycle k+1.
  - Minimum request-to-done: 2 cycles.
- Latency, illegal access: done in cycle 1; mem_req never asserts.
- Timeout: mem_req asserts for exactly TIMEOUT_CYCLES cycles, done follows in the next cycle, and the bus is released in the done cycle.
- req while busy=1 (including the DONE cycle) is ignored; the requester must hold req until it sees busy.
- ack outside ACCESS is ignored. An ack arriving in the same cycle the counter hits the limit counts as success, not timeout.
- Back-to-back: a req in the first IDLE cycle after DONE is accepted, giving a 3-cycle minimum period per access.

## Test plan
- LB sign extension: load addr=0x1003, ack in cycle 1 with rdata=0x80AB_CDEF → done cycle 2, load_data=0xFFFF_FF80, mem_addr=0x1000, be=0000.
- SH upper half: store funct3=001, addr=0x2002, sd=0x1234_BEEF → mem_we=1, be=1100, wdata=0xBEEF_BEEF; ack after 3 wait cycles → done 1 cycle later, load_data unchanged.
- Misaligned LW: addr=0x3001 → mem_req never 1, done in cycle 1 with misaligned=1, load_data=0. Repeat with funct3=011 → same response.
- Timeout: TIMEOUT_CYCLES=4, ack held 0 → mem_req high cycles 1–4, done+timeout in cycle 5, mem_req 0 from cycle 5.
- Busy/ignored inputs: hold req=1 continuously across three LBU loads → done every 3 cycles with exactly one bus access each. A spurious ack in IDLE causes no state change.
- Reset mid-access: assert rst in cycle 2 of ACCESS → all outputs 0 immediately, no done. After release, a new LW at 0x10 with rdata=0xDEAD_BEEF → load_data=0xDEAD_BEEF.
